// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding memory responder with fixed response latency.
// Accepts one load/store request at a time, holds it for LATENCY edges, then presents
// a response until the initiator takes it.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req_valid   request presented by the initiator
//   req_ready   responder can accept a request (IDLE only)
//   req_we      1 = store, 0 = load
//   req_addr    byte address (must be word aligned and inside DEPTH_WORDS)
//   req_wdata   store data
//   req_wstrb   store byte enables, bit i covers wdata[8i+7:8i]
//   resp_valid  response presented
//   resp_ready  initiator accepts the response
//   resp_rdata  load data; zero for stores and errors
//   resp_err    request was misaligned or out of range
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;
    logic            we_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept_c;
    logic            req_err_c;
    logic [AW-1:0]   req_idx_c;

    // Request decode: acceptance, error check and word index.
    always_comb begin
        accept_c  = req_valid && req_ready_q && !reset;
        req_err_c = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
        req_idx_c = req_addr[AW+1:2];
    end

    // Storage array: not reset, written only by a valid store at its acceptance edge.
    always_ff @(posedge clk) begin
        if (accept_c && req_we && !req_err_c) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) begin
                    mem_q[req_idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    // LATENCY=1 loads a zero count, so WAIT lasts one cycle and resp_valid still
    // rises exactly LATENCY edges after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        err_q       <= req_err_c;
                        idx_q       <= req_idx_c;
                        cnt_q       <= CW'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        // Any store from this transaction committed at the acceptance edge.
                        resp_rdata_q <= (we_q || err_q) ? 32'd0 : mem_q[idx_q];
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total;
    int bad;

    logic [31:0] rd;
    logic        er;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: present, accept, measure latency, optional backpressure, handshake.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                        output logic [31:0] rd_o, output logic er_o);
        int          n;
        logic [31:0] rd0;
        logic        er0;
        logic        hold_ok;
        chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        step();
        // Junk on the request bus after acceptance must be ignored.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0040;
        req_wdata = $urandom;
        req_wstrb = 4'hF;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        rd0 = resp_rdata;
        er0 = resp_err;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!(resp_valid === 1'b1 && resp_rdata === rd0 && resp_err === er0 && req_ready === 1'b0))
                hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, " stable_under_backpressure"}, 32'(hold_ok), 32'd1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, " after_handshake"}, 32'({resp_valid, req_ready}), 32'b01);
        rd_o = rd0;
        er_o = er0;
    endtask

    initial begin
        int          acc_q[$];
        int          cyc;
        logic        acc;
        logic        seen;
        logic        overlap;
        logic        data_bad;

        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b0;

        step();
        step();
        step();
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);

        // First request presented right away: accepted on the first edge with reset low.
        reset = 1'b0;
        xact("st_deadbeef", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        chk("st_deadbeef rdata", rd, 32'd0);
        chk("st_deadbeef err", 32'(er), 32'd0);
        xact("ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld_10 rdata", rd, 32'hDEAD_BEEF);
        chk("ld_10 err", 32'(er), 32'd0);

        // Byte strobes.
        xact("st_20_full", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd, er);
        xact("st_20_strb5", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
        chk("st_20_strb5 err", 32'(er), 32'd0);
        xact("ld_20", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("ld_20 rdata", rd, 32'h11BB_33DD);

        // Zero strobe: no change, no error.
        xact("st_20_strb0", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
        chk("st_20_strb0 err", 32'(er), 32'd0);
        chk("st_20_strb0 rdata", rd, 32'd0);
        xact("ld_20_again", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("ld_20_again rdata", rd, 32'h11BB_33DD);

        // Errors: out-of-range store must not alias onto word 0.
        xact("st_0", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 0, rd, er);
        xact("st_400", 1'b1, 32'h400, 32'h1234_5678, 4'hF, 0, rd, er);
        chk("st_400 err", 32'(er), 32'd1);
        chk("st_400 rdata", rd, 32'd0);
        xact("ld_0", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        chk("ld_0 rdata", rd, 32'hCAFE_F00D);
        chk("ld_0 err", 32'(er), 32'd0);
        xact("ld_13", 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er);
        chk("ld_13 err", 32'(er), 32'd1);
        chk("ld_13 rdata", rd, 32'd0);
        xact("st_22_misaligned", 1'b1, 32'h22, 32'h9999_9999, 4'hF, 0, rd, er);
        chk("st_22_misaligned err", 32'(er), 32'd1);
        xact("ld_20_post_err", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("ld_20_post_err rdata", rd, 32'h11BB_33DD);

        // Last in-range word.
        xact("st_3fc", 1'b1, 32'h3FC, 32'h1357_9BDF, 4'hF, 0, rd, er);
        chk("st_3fc err", 32'(er), 32'd0);
        xact("ld_3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er);
        chk("ld_3fc rdata", rd, 32'h1357_9BDF);
        chk("ld_3fc err", 32'(er), 32'd0);

        // Backpressure for 5 cycles.
        xact("ld_10_bp", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
        chk("ld_10_bp rdata", rd, 32'hDEAD_BEEF);

        // Reset one cycle after accepting a load.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_wait req_ready", 32'(req_ready), 32'd1);
        chk("rst_wait resp_valid", 32'(resp_valid), 32'd0);
        step();
        step();
        chk("rst_held req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b0) seen = 1'b1;
            step();
        end
        chk("rst_wait no_response", 32'(seen), 32'd0);
        xact("ld_10_post_rst", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld_10_post_rst rdata", rd, 32'hDEAD_BEEF);

        // Back-to-back: two WAIT cycles plus one RESP cycle separate acceptances.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h20;
        overlap    = 1'b0;
        data_bad   = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            acc = req_ready;
            step();
            if (acc === 1'b1) acc_q.push_back(cyc);
            if (req_ready === 1'b1 && resp_valid === 1'b1) overlap = 1'b1;
            if (resp_valid === 1'b1 && resp_rdata !== 32'h11BB_33DD) data_bad = 1'b1;
        end
        req_valid  = 1'b0;
        step();
        resp_ready = 1'b0;
        chk("b2b accept_count", 32'(acc_q.size()), 32'd5);
        for (int i = 1; i < acc_q.size(); i++) begin
            chk("b2b spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd4);
        end
        chk("b2b no_overlap", 32'(overlap), 32'd0);
        chk("b2b rdata", 32'(data_bad), 32'd0);
        chk("b2b idle_after", 32'({resp_valid, req_ready}), 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
